// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the instruction cache: geometry, derived address-field widths,
// field typedefs, FSM state encoding and a helper to rebuild a word address from its fields.
package icache_fetch_pkg;

    localparam int unsigned WordSize  = 16;
    localparam int unsigned LineWords = 4;   // power of 2
    localparam int unsigned NumLines  = 4;   // power of 2
    localparam int unsigned OfsW      = $clog2(LineWords);
    localparam int unsigned IdxW      = $clog2(NumLines);
    localparam int unsigned TagW      = WordSize - OfsW - IdxW;

    typedef logic [WordSize-1:0] word_t;
    typedef logic [TagW-1:0]     tag_t;
    typedef logic [IdxW-1:0]     idx_t;
    typedef logic [OfsW-1:0]     ofs_t;

    typedef enum logic {
        StIdle = 1'b0,
        StFill = 1'b1
    } state_e;

    function automatic word_t line_addr(tag_t tag, idx_t idx, ofs_t ofs);
        return {tag, idx, ofs};
    endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// Fetch-port and memory-port bundle of the instruction cache.
//   cpu_read/cpu_address  -> cache : fetch request and word address (PC)
//   cpu_data/cpu_ready    <- cache : instruction and its valid strobe (0 = stall)
//   mem_read/mem_address  <- cache : line-fill request and current beat address
//   mem_data/mem_valid    -> cache : one fill beat per mem_valid cycle
// slave  : the cache side.  master : the datapath + memory side.
interface icache_fetch_if;
    import icache_fetch_pkg::*;

    logic  cpu_read;
    word_t cpu_address;
    word_t cpu_data;
    logic  cpu_ready;
    logic  mem_read;
    word_t mem_address;
    word_t mem_data;
    logic  mem_valid;

    modport slave (
        input  cpu_read, cpu_address, mem_data, mem_valid,
        output cpu_data, cpu_ready, mem_read, mem_address
    );

    modport master (
        output cpu_read, cpu_address, mem_data, mem_valid,
        input  cpu_data, cpu_ready, mem_read, mem_address
    );

endinterface

// File: rtl/icache_fetch_array.sv
// Valid/tag/data storage of the direct-mapped cache.
//   Clk, Reset_N            : clock, synchronous active-low reset (clears valid bits only)
//   rd_idx_i, rd_ofs_i      : async read address -> rd_valid_o, rd_tag_o, rd_data_o
//   wr_en_i, wr_idx_i,
//   wr_ofs_i, wr_data_i     : sync single-word write
//   fill_done_i, fill_tag_i : on line completion write tag and set valid for wr_idx_i
module icache_fetch_array
    import icache_fetch_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset_N,
    input  idx_t  rd_idx_i,
    input  ofs_t  rd_ofs_i,
    output logic  rd_valid_o,
    output tag_t  rd_tag_o,
    output word_t rd_data_o,
    input  logic  wr_en_i,
    input  idx_t  wr_idx_i,
    input  ofs_t  wr_ofs_i,
    input  word_t wr_data_i,
    input  logic  fill_done_i,
    input  tag_t  fill_tag_i
);

    logic [NumLines-1:0] valid_q;
    tag_t                tag_q  [NumLines];
    word_t               data_q [NumLines][LineWords];

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            valid_q <= '0;
        end else if (fill_done_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: nothing reads them while the valid bit is clear.
    always_ff @(posedge Clk) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_ofs_i] <= wr_data_i;
        end
        if (fill_done_i) begin
            tag_q[wr_idx_i] <= fill_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_ofs_i];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache in front of a multi-cycle memory.
// Hits answer in the same cycle; a miss stalls fetch and burst-fills the whole line.
//   Clk, Reset_N   : clock, synchronous active-low reset
//   cache_io       : fetch port (cpu_*) and line-fill port (mem_*), see icache_fetch_if
//   hit_count_o    : ready cycles serviced from the cache (wraps)
//   miss_count_o   : fills started (wraps)
module icache_fetch
    import icache_fetch_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset_N,
    icache_fetch_if.slave cache_io,
    output word_t         hit_count_o,
    output word_t         miss_count_o
);

    state_e state_q, state_d;
    ofs_t   beat_q, beat_d;
    tag_t   base_tag_q, base_tag_d;
    idx_t   base_idx_q, base_idx_d;
    word_t  hit_cnt_q, hit_cnt_d;
    word_t  miss_cnt_q, miss_cnt_d;

    tag_t  req_tag;
    idx_t  req_idx;
    ofs_t  req_ofs;
    logic  rd_valid;
    tag_t  rd_tag;
    word_t rd_data;
    logic  hit;
    logic  wr_en;
    logic  fill_done;

    assign req_tag = cache_io.cpu_address[WordSize-1 -: TagW];
    assign req_idx = cache_io.cpu_address[OfsW+IdxW-1 : OfsW];
    assign req_ofs = cache_io.cpu_address[OfsW-1 : 0];

    // A fill writes the latched line, not whatever the datapath is presenting now.
    assign wr_en     = (state_q == StFill) && cache_io.mem_valid;
    assign fill_done = wr_en && (beat_q == ofs_t'(LineWords - 1));

    icache_fetch_array u_array (
        .Clk         (Clk),
        .Reset_N     (Reset_N),
        .rd_idx_i    (req_idx),
        .rd_ofs_i    (req_ofs),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_idx_i    (base_idx_q),
        .wr_ofs_i    (beat_q),
        .wr_data_i   (cache_io.mem_data),
        .fill_done_i (fill_done),
        .fill_tag_i  (base_tag_q)
    );

    assign hit = cache_io.cpu_read && rd_valid && (rd_tag == req_tag) && (state_q == StIdle);

    always_comb begin
        cache_io.cpu_ready   = hit;
        cache_io.cpu_data    = hit ? rd_data : '0;
        cache_io.mem_read    = (state_q == StFill);
        cache_io.mem_address = (state_q == StFill) ? line_addr(base_tag_q, base_idx_q, beat_q)
                                                   : '0;
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_tag_d = base_tag_q;
        base_idx_d = base_idx_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cache_io.cpu_read) begin
                    if (hit) begin
                        hit_cnt_d = hit_cnt_q + word_t'(1);
                    end else begin
                        miss_cnt_d = miss_cnt_q + word_t'(1);
                        base_tag_d = req_tag;
                        base_idx_d = req_idx;
                        beat_d     = '0;
                        state_d    = StFill;
                    end
                end
            end
            StFill: begin
                if (cache_io.mem_valid) begin
                    beat_d = beat_q + ofs_t'(1);
                    if (fill_done) begin
                        beat_d  = '0;
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            base_tag_q <= '0;
            base_idx_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_tag_q <= base_tag_d;
            base_idx_q <= base_idx_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_icache_fetch.sv
module tb_icache_fetch;
    import icache_fetch_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    word_t hit_count;
    word_t miss_count;

    always #5 clk = ~clk;

    icache_fetch_if bus ();

    icache_fetch dut (
        .Clk          (clk),
        .Reset_N      (rst_n),
        .cache_io     (bus),
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
    );

    int checks   = 0;
    int failures = 0;

    word_t exp_data_q[$];      // expected cpu_data, one per completed fetch
    word_t exp_addr_q[$];      // expected fill beat addresses, in order
    bit          mvalid[NumLines];
    int unsigned mline[NumLines];   // full line number (address / LineWords) held per index
    word_t       mhits;
    word_t       mmisses;

    bit stray_en   = 1'b0;
    int beats_done = 0;
    int wait_cnt   = 0;

    function automatic word_t memval(word_t a);
        word_t p;
        p = a * 16'd40503;
        return p ^ 16'h1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NumLines; i++) begin
            mvalid[i] = 1'b0;
            mline[i]  = 0;
        end
        mhits   = '0;
        mmisses = '0;
    endtask

    // Reference lookup: a line is present iff its index slot holds exactly this line number.
    // On a miss the whole line is expected from memory in ascending order and then present.
    task automatic model_access(input word_t a, output bit was_hit);
        int unsigned line;
        int unsigned idx;
        line = int'(a) / LineWords;
        idx  = line % NumLines;
        was_hit = mvalid[idx] && (mline[idx] == line);
        if (!was_hit) begin
            for (int k = 0; k < LineWords; k++) begin
                exp_addr_q.push_back(word_t'(line * LineWords + k));
            end
            mmisses   = mmisses + 1'b1;
            mvalid[idx] = 1'b1;
            mline[idx]  = line;
        end
    endtask

    // Memory: answers each beat after 0..2 idle cycles; optionally throws stray beats.
    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_valid = 1'b0;
            if (rst_n !== 1'b1) begin
                wait_cnt = 0;
            end else if (bus.mem_read === 1'b1) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL fill_request: unexpected beat at 0x%0h", bus.mem_address);
                    end else begin
                        chk("mem_address", bus.mem_address, exp_addr_q.pop_front());
                    end
                    bus.mem_valid = 1'b1;
                    bus.mem_data  = memval(bus.mem_address);
                    beats_done++;
                    wait_cnt = $urandom_range(0, 2);
                end
            end else if (stray_en) begin
                bus.mem_valid = 1'($urandom_range(0, 1));
                bus.mem_data  = word_t'($urandom);
            end
        end
    end

    // Scoreboard monitor: every ready cycle must deliver the oldest outstanding fetch.
    always @(negedge clk) begin
        if (bus.cpu_ready === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: data 0x%0h with no fetch pending", bus.cpu_data);
            end else begin
                chk("cpu_data", bus.cpu_data, exp_data_q.pop_front());
            end
        end
    end

    task automatic wait_ready(input bit was_hit, input bit redirected);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.cpu_ready !== 1'b1 && n < 60);
        if (bus.cpu_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout: no ready after %0d cycles at 0x%0h", n, bus.cpu_address);
        end else if (was_hit && !redirected) begin
            chk("hit_latency", n, 1);
        end else begin
            checks++;
            if (n < (redirected ? 2 : LineWords + 2)) begin
                failures++;
                $display("FAIL stall_length: ready after %0d cycles, required more", n);
            end
        end
    endtask

    task automatic fetch(input word_t a, input bit redirected);
        bit h;
        model_access(a, h);
        exp_data_q.push_back(memval(a));
        mhits = mhits + 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_read    = 1'b1;
        bus.cpu_address = a;
        wait_ready(h, redirected);
    endtask

    // Start a miss on a, then move the PC to b while a's line is still filling.
    task automatic redirect(input word_t a, input word_t b);
        bit h;
        model_access(a, h);
        if (h) begin
            exp_data_q.push_back(memval(a));
            mhits = mhits + 1'b1;
            @(posedge clk);
            #1;
            bus.cpu_read    = 1'b1;
            bus.cpu_address = a;
            wait_ready(h, 1'b0);
            fetch(b, 1'b0);
        end else begin
            @(posedge clk);
            #1;
            bus.cpu_read    = 1'b1;
            bus.cpu_address = a;
            repeat (2) @(negedge clk);
            chk("fill_ready", bus.cpu_ready, 0);
            chk("fill_cpu_data", bus.cpu_data, 0);
            chk("fill_mem_read", bus.mem_read, 1);
            fetch(b, 1'b1);
        end
    endtask

    task automatic idle(input int cycles);
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_counters();
        idle(1);
        chk("hit_count", hit_count, mhits);
        chk("miss_count", miss_count, mmisses);
    endtask

    task automatic check_reset_outputs();
        chk("rst_cpu_ready", bus.cpu_ready, 0);
        chk("rst_cpu_data", bus.cpu_data, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
    endtask

    task automatic reset_mid_fill(input word_t a);
        bit h;
        int n;
        model_access(a, h);
        beats_done = 0;
        @(posedge clk);
        #1;
        bus.cpu_read    = 1'b1;
        bus.cpu_address = a;
        n = 0;
        while (beats_done < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("fill_beats_seen", (beats_done >= 2), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
        exp_addr_q.delete();
        model_clear();
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.cpu_read    = 1'b0;
        bus.cpu_address = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cold miss on line 0, then sequential hits within it.
        fetch(16'h0000, 1'b0);
        check_counters();
        fetch(16'h0001, 1'b0);
        fetch(16'h0002, 1'b0);
        fetch(16'h0003, 1'b0);
        check_counters();

        // Same index, different tag: both directions miss.
        fetch(16'h0010, 1'b0);
        fetch(16'h0000, 1'b0);
        check_counters();

        // PC redirect while filling; the abandoned line still completes.
        redirect(16'h0004, 16'h0020);
        fetch(16'h0005, 1'b0);
        check_counters();

        // Idle with stray memory beats changes nothing.
        stray_en = 1'b1;
        idle(5);
        stray_en = 1'b0;
        check_counters();
        fetch(16'h0006, 1'b0);
        fetch(16'h0021, 1'b0);

        // Reset in the middle of a fill, then the same address must refill from scratch.
        reset_mid_fill(16'h0044);
        fetch(16'h0044, 1'b0);
        fetch(16'h0047, 1'b0);
        check_counters();

        // Random fetch stream over a few conflicting lines.
        for (int i = 0; i < 150; i++) begin
            word_t a;
            word_t b;
            a = word_t'($urandom_range(0, 127));
            b = word_t'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) begin
                redirect(a, b);
            end else begin
                fetch(a, 1'b0);
            end
            if (i % 25 == 24) begin
                check_counters();
            end
        end

        check_counters();
        idle(3);
        chk("data_scoreboard_drained", exp_data_q.size(), 0);
        chk("fill_scoreboard_drained", exp_addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
